// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SQUASH  = 2'd1,
        HALT    = 2'd2,
        UNUSED3 = 2'd3
    } ctlStateT;

    localparam int BRANCH_SHADOW_DEF = 3;
    localparam logic [4:0] ZERO_REG = 5'd0;

    // A counter reaching BRANCH_SHADOW-1 needs at least one bit even for a shadow of 1.
    function automatic int cntWidth(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Decoder/datapath-facing signal bundle of the pipeline hazard controller.
interface pipe_hazard_ctl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] decodeRfRdAdrx0;
    logic [ADDR_W-1:0] decodeRfRdAdrx1;
    logic              decodeUsesRd0;
    logic              decodeUsesRd1;
    logic              decodeIsLoad;
    logic [ADDR_W-1:0] decodeLoadDest;
    logic              branchTaken;
    logic              haltReq;
    logic              resumeReq;
    logic              pcEn;
    logic              irEn;
    logic              bubble;
    logic              doBranchHeld;
    logic [1:0]        ctlState;
    logic [CNT_W-1:0]  stallCount;

    modport master (
        output decodeRfRdAdrx0, decodeRfRdAdrx1, decodeUsesRd0, decodeUsesRd1,
               decodeIsLoad, decodeLoadDest, branchTaken, haltReq, resumeReq,
        input  pcEn, irEn, bubble, doBranchHeld, ctlState, stallCount
    );

    modport slave (
        input  decodeRfRdAdrx0, decodeRfRdAdrx1, decodeUsesRd0, decodeUsesRd1,
               decodeIsLoad, decodeLoadDest, branchTaken, haltReq, resumeReq,
        output pcEn, irEn, bubble, doBranchHeld, ctlState, stallCount
    );
endinterface

// File: rtl/pipe_hazard_ctl_squash_counter.sv
// Loadable down-counter timing the branch shadow; flags when it has reached zero.
module squash_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] loadVal,
    output logic         isZero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign isZero = (cnt == '0);
endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline control: load-use stalls, branch-shadow squash, halt/resume.
// States: RUN normal issue | SQUASH branch shadow, writes suppressed | HALT pipeline frozen
module pipe_hazard_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int BRANCH_SHADOW = BRANCH_SHADOW_DEF,
    parameter int ADDR_W        = 5,
    parameter int CNT_W         = 16
) (
    input logic              clk,
    input logic              rst_n,
    pipe_hazard_ctl_if.slave ctlIf
);
    localparam int SQW = cntWidth(BRANCH_SHADOW);
    localparam logic [SQW-1:0] SHADOW_LOAD = SQW'(BRANCH_SHADOW - 1);

    ctlStateT          state, stateNext;
    logic              execIsLoad;
    logic [ADDR_W-1:0] execLoadDest;
    logic              loadUse;
    logic              squashLoad, squashDec, squashZero;
    logic              pcEn, irEn, bubble;
    logic [CNT_W-1:0]  stallCount;

    squash_counter #(.W(SQW)) uSquashCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (squashLoad),
        .dec     (squashDec),
        .loadVal (SHADOW_LOAD),
        .isZero  (squashZero)
    );

    // Load data arrives a cycle after execute, so a dependent decode must wait once.
    assign loadUse = execIsLoad && (execLoadDest != ADDR_W'(ZERO_REG)) &&
                     ((ctlIf.decodeUsesRd0 && ctlIf.decodeRfRdAdrx0 == execLoadDest) ||
                      (ctlIf.decodeUsesRd1 && ctlIf.decodeRfRdAdrx1 == execLoadDest));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        squashLoad = 1'b0;
        squashDec  = 1'b0;
        case (state)
            RUN: begin
                if (ctlIf.branchTaken) begin
                    stateNext  = SQUASH;
                    squashLoad = 1'b1;
                end else if (loadUse) begin
                    stateNext = RUN;
                end else if (ctlIf.haltReq) begin
                    stateNext = HALT;
                end
            end
            SQUASH: begin
                if (squashZero) stateNext = RUN;
                else            squashDec = 1'b1;
            end
            HALT: begin
                if (ctlIf.resumeReq) stateNext = RUN;
            end
            default: stateNext = RUN;
        endcase
    end

    always_comb begin
        pcEn   = 1'b1;
        irEn   = 1'b1;
        bubble = 1'b0;
        case (state)
            RUN: begin
                if (ctlIf.branchTaken) begin
                    bubble = 1'b1;
                end else if (loadUse || ctlIf.haltReq) begin
                    pcEn   = 1'b0;
                    irEn   = 1'b0;
                    bubble = 1'b1;
                end
            end
            SQUASH: bubble = 1'b1;
            HALT: begin
                pcEn   = 1'b0;
                irEn   = 1'b0;
                bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            execIsLoad   <= 1'b0;
            execLoadDest <= '0;
            stallCount   <= '0;
        end else begin
            execIsLoad   <= ctlIf.decodeIsLoad & ~bubble;
            execLoadDest <= ctlIf.decodeLoadDest;
            if (!pcEn && stallCount != '1) begin
                stallCount <= stallCount + CNT_W'(1);
            end
        end
    end

    assign ctlIf.pcEn         = pcEn;
    assign ctlIf.irEn         = irEn;
    assign ctlIf.bubble       = bubble;
    assign ctlIf.doBranchHeld = (state == SQUASH);
    assign ctlIf.ctlState     = state;
    assign ctlIf.stallCount   = stallCount;
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed self-checking bench for pipe_hazard_ctl (BRANCH_SHADOW=3, plus a CNT_W=2 instance).
module tb_pipe_hazard_ctl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctl_if #(.ADDR_W(5), .CNT_W(16)) bus ();
    pipe_hazard_ctl_if #(.ADDR_W(5), .CNT_W(2))  bus2 ();

    pipe_hazard_ctl #(.BRANCH_SHADOW(3), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ctlIf(bus)
    );
    pipe_hazard_ctl #(.BRANCH_SHADOW(3), .ADDR_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ctlIf(bus2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.decodeRfRdAdrx0 = 5'd0;  bus.decodeRfRdAdrx1 = 5'd0;
        bus.decodeUsesRd0 = 1'b0;    bus.decodeUsesRd1 = 1'b0;
        bus.decodeIsLoad = 1'b0;     bus.decodeLoadDest = 5'd0;
        bus.branchTaken = 1'b0;      bus.haltReq = 1'b0;  bus.resumeReq = 1'b0;
        bus2.decodeRfRdAdrx0 = 5'd0; bus2.decodeRfRdAdrx1 = 5'd0;
        bus2.decodeUsesRd0 = 1'b0;   bus2.decodeUsesRd1 = 1'b0;
        bus2.decodeIsLoad = 1'b0;    bus2.decodeLoadDest = 5'd0;
        bus2.branchTaken = 1'b0;     bus2.haltReq = 1'b0; bus2.resumeReq = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        total++;
        if ({bus.pcEn, bus.irEn, bus.bubble} !== 3'b110) begin
            bad++; $display("FAIL reset_ctl got=%b exp=110", {bus.pcEn, bus.irEn, bus.bubble});
        end
        total++;
        if (bus.ctlState !== 2'd0 || bus.doBranchHeld !== 1'b0 || bus.stallCount !== 16'd0) begin
            bad++; $display("FAIL reset_regs state=%0d held=%b cnt=%0d exp 0/0/0",
                            bus.ctlState, bus.doBranchHeld, bus.stallCount);
        end
        bus.haltReq = 1'b1;
        #1;
        total++;
        if (bus.pcEn !== 1'b0) begin
            bad++; $display("FAIL reset_halt_pcEn got=%b exp=0", bus.pcEn);
        end
        bus.haltReq = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        bus.decodeIsLoad = 1'b1; bus.decodeLoadDest = 5'd3;
        @(negedge clk);
        total++;
        if ({bus.pcEn, bus.irEn, bus.bubble} !== 3'b110) begin
            bad++; $display("FAIL lu_load_cycle got=%b exp=110", {bus.pcEn, bus.irEn, bus.bubble});
        end
        step();
        bus.decodeIsLoad = 1'b0; bus.decodeRfRdAdrx1 = 5'd3; bus.decodeUsesRd1 = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.pcEn, bus.irEn, bus.bubble} !== 3'b001) begin
            bad++; $display("FAIL lu_stall got=%b exp=001", {bus.pcEn, bus.irEn, bus.bubble});
        end
        total++;
        if (bus.stallCount !== 16'd0) begin
            bad++; $display("FAIL lu_cnt_before got=%0d exp=0", bus.stallCount);
        end
        step();
        @(negedge clk);
        total++;
        if ({bus.pcEn, bus.irEn, bus.bubble} !== 3'b110 || bus.ctlState !== 2'd0) begin
            bad++; $display("FAIL lu_after got=%b state=%0d exp=110 state=0",
                            {bus.pcEn, bus.irEn, bus.bubble}, bus.ctlState);
        end
        total++;
        if (bus.stallCount !== 16'd1) begin
            bad++; $display("FAIL lu_cnt_after got=%0d exp=1", bus.stallCount);
        end
        step();
        idle();
    endtask

    task automatic test_no_stall();
        bus.decodeIsLoad = 1'b1; bus.decodeLoadDest = 5'd0;
        step();
        bus.decodeIsLoad = 1'b0; bus.decodeRfRdAdrx0 = 5'd0; bus.decodeUsesRd0 = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.pcEn, bus.bubble} !== 2'b10) begin
            bad++; $display("FAIL r0_no_stall got=%b exp=10", {bus.pcEn, bus.bubble});
        end
        step();
        bus.decodeIsLoad = 1'b1; bus.decodeLoadDest = 5'd3; bus.decodeUsesRd0 = 1'b0;
        step();
        bus.decodeIsLoad = 1'b0; bus.decodeRfRdAdrx0 = 5'd3; bus.decodeRfRdAdrx1 = 5'd3;
        @(negedge clk);
        total++;
        if ({bus.pcEn, bus.bubble} !== 2'b10) begin
            bad++; $display("FAIL unused_src_no_stall got=%b exp=10", {bus.pcEn, bus.bubble});
        end
        step();
        total++;
        if (bus.stallCount !== 16'd1) begin
            bad++; $display("FAIL no_stall_cnt got=%0d exp=1", bus.stallCount);
        end
        idle();
    endtask

    task automatic test_branch();
        logic [3:0] expHeld;
        logic [3:0] expBubble;
        expHeld   = 4'b0111;
        expBubble = 4'b0111;
        idle();
        bus.branchTaken = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.pcEn, bus.irEn, bus.bubble, bus.doBranchHeld} !== 4'b1110 || bus.ctlState !== 2'd0) begin
            bad++; $display("FAIL br_pulse got=%b state=%0d exp=1110 state=0",
                            {bus.pcEn, bus.irEn, bus.bubble, bus.doBranchHeld}, bus.ctlState);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            bus.branchTaken = (i == 1);
            @(negedge clk);
            total++;
            if (bus.doBranchHeld !== expHeld[i] || bus.bubble !== expBubble[i] ||
                bus.ctlState !== {1'b0, expHeld[i]} || bus.pcEn !== 1'b1) begin
                bad++; $display("FAIL br_window[%0d] held=%b bubble=%b state=%0d pcEn=%b exp held=%b bubble=%b",
                                i, bus.doBranchHeld, bus.bubble, bus.ctlState, bus.pcEn,
                                expHeld[i], expBubble[i]);
            end
            step();
        end
        idle();
    endtask

    task automatic test_branch_loaduse();
        bus.decodeIsLoad = 1'b1; bus.decodeLoadDest = 5'd5;
        step();
        bus.decodeIsLoad = 1'b0; bus.decodeRfRdAdrx0 = 5'd5; bus.decodeUsesRd0 = 1'b1;
        bus.branchTaken = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.pcEn, bus.irEn, bus.bubble} !== 3'b111) begin
            bad++; $display("FAIL br_lu_prio got=%b exp=111", {bus.pcEn, bus.irEn, bus.bubble});
        end
        step();
        bus.branchTaken = 1'b0;
        @(negedge clk);
        total++;
        if (bus.ctlState !== 2'd1 || bus.stallCount !== 16'd1) begin
            bad++; $display("FAIL br_lu_squash state=%0d cnt=%0d exp state=1 cnt=1",
                            bus.ctlState, bus.stallCount);
        end
        step(); step(); step();
        @(negedge clk);
        total++;
        if (bus.ctlState !== 2'd0 || bus.pcEn !== 1'b1 || bus.stallCount !== 16'd1) begin
            bad++; $display("FAIL br_lu_exit state=%0d pcEn=%b cnt=%0d exp 0/1/1",
                            bus.ctlState, bus.pcEn, bus.stallCount);
        end
        step();
        idle();
    endtask

    task automatic test_halt();
        bus.haltReq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.pcEn !== 1'b0 || bus.irEn !== 1'b0 || bus.ctlState !== ((i == 0) ? 2'd0 : 2'd2)) begin
                bad++; $display("FAIL halt[%0d] pcEn=%b irEn=%b state=%0d exp pcEn=0 state=%0d",
                                i, bus.pcEn, bus.irEn, bus.ctlState, (i == 0) ? 0 : 2);
            end
            step();
        end
        bus.haltReq = 1'b0; bus.resumeReq = 1'b1;
        @(negedge clk);
        total++;
        if (bus.pcEn !== 1'b0 || bus.ctlState !== 2'd2) begin
            bad++; $display("FAIL halt_resume_cycle pcEn=%b state=%0d exp 0/2", bus.pcEn, bus.ctlState);
        end
        step();
        bus.resumeReq = 1'b0;
        @(negedge clk);
        total++;
        if (bus.pcEn !== 1'b1 || bus.ctlState !== 2'd0 || bus.stallCount !== 16'd7) begin
            bad++; $display("FAIL halt_after pcEn=%b state=%0d cnt=%0d exp 1/0/7",
                            bus.pcEn, bus.ctlState, bus.stallCount);
        end
        step();
        idle();
    endtask

    task automatic test_halt_in_squash();
        bus.branchTaken = 1'b1;
        step();
        bus.branchTaken = 1'b0; bus.haltReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.ctlState !== 2'd1 || bus.pcEn !== 1'b1) begin
                bad++; $display("FAIL hs_squash[%0d] state=%0d pcEn=%b exp 1/1", i, bus.ctlState, bus.pcEn);
            end
            step();
        end
        @(negedge clk);
        total++;
        if (bus.ctlState !== 2'd0 || bus.pcEn !== 1'b0) begin
            bad++; $display("FAIL hs_run_halt state=%0d pcEn=%b exp 0/0", bus.ctlState, bus.pcEn);
        end
        step();
        bus.haltReq = 1'b0; bus.resumeReq = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ctlState !== 2'd2) begin
            bad++; $display("FAIL hs_halted state=%0d exp=2", bus.ctlState);
        end
        step();
        bus.resumeReq = 1'b0;
        @(negedge clk);
        total++;
        if (bus.ctlState !== 2'd0 || bus.stallCount !== 16'd9) begin
            bad++; $display("FAIL hs_done state=%0d cnt=%0d exp 0/9", bus.ctlState, bus.stallCount);
        end
        step();
        idle();
    endtask

    task automatic test_reset_mid_squash();
        bus.branchTaken = 1'b1;
        step();
        bus.branchTaken = 1'b0;
        @(negedge clk);
        total++;
        if (bus.doBranchHeld !== 1'b1) begin
            bad++; $display("FAIL rs_pre_held got=%b exp=1", bus.doBranchHeld);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.doBranchHeld !== 1'b0 || bus.ctlState !== 2'd0 || bus.stallCount !== 16'd0) begin
            bad++; $display("FAIL rs_async held=%b state=%0d cnt=%0d exp 0/0/0",
                            bus.doBranchHeld, bus.ctlState, bus.stallCount);
        end
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (bus.ctlState !== 2'd0 || bus.doBranchHeld !== 1'b0 ||
            {bus.pcEn, bus.irEn, bus.bubble} !== 3'b110 || bus.stallCount !== 16'd0) begin
            bad++; $display("FAIL rs_after state=%0d held=%b ctl=%b cnt=%0d exp 0/0/110/0",
                            bus.ctlState, bus.doBranchHeld, {bus.pcEn, bus.irEn, bus.bubble},
                            bus.stallCount);
        end
        step();
    endtask

    task automatic test_saturate();
        int expCnt;
        idle();
        bus2.haltReq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expCnt = (i + 1 > 3) ? 3 : i + 1;
            @(negedge clk);
            total++;
            if (bus2.stallCount !== 2'(expCnt)) begin
                bad++; $display("FAIL sat[%0d] got=%0d exp=%0d", i, bus2.stallCount, expCnt);
            end
        end
        step();
        bus2.haltReq = 1'b0; bus2.resumeReq = 1'b1;
        step();
        bus2.resumeReq = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (bus2.stallCount !== 2'd3 || bus2.ctlState !== 2'd0) begin
            bad++; $display("FAIL sat_hold cnt=%0d state=%0d exp 3/0", bus2.stallCount, bus2.ctlState);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_branch_loaduse();
        test_halt();
        test_halt_in_squash();
        test_reset_mid_squash();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Pipeline control unit for the three-stage CPU pipeline (fetch/decode → execute → writeback). It owns the three pipeline-control decisions:
- Load-use stalls, which register forwarding cannot cover because data-memory output is only valid one cycle after execute.
- Squashing of shadow instructions after a taken branch.
- Software-requested halt and resume.

It sits between the instruction decoder and the datapath. It gates the PC and instruction register and forces bubbles (write enables low) into the execute stage.

## Interface
Parameters:
- BRANCH_SHADOW, 3: number of cycles squashed after a taken branch; legal range 1–7.
- ADDR_W, 5: register-file address width.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- decodeRfRdAdrx0  in  ADDR_W  first source register of the instruction in decode.
- decodeRfRdAdrx1  in  ADDR_W  second source register of the instruction in decode.
- decodeUsesRd0  in  1  decode instruction actually reads source 0.
- decodeUsesRd1  in  1  decode instruction actually reads source 1.
- decodeIsLoad  in  1  decode instruction is a load.
- decodeLoadDest  in  ADDR_W  destination register of that load.
- branchTaken  in  1  execute-stage branch resolved taken; single-cycle pulse.
- haltReq  in  1  level; request to halt the pipeline.
- resumeReq  in  1  level; leave HALT.
- pcEn  out  1  PC may advance this cycle.
- irEn  out  1  instruction register may load this cycle.
- bubble  out  1  zero the write enables of the decode→execute transfer this cycle.
- doBranchHeld  out  1  squash window active; gates the execute-stage register-file write.
- ctlState  out  2  current state, for debug.
- stallCount  out  CNT_W  saturating count of cycles with pcEn=0.

## Operation
State machine, encoding in the package:
- RUN=0, SQUASH=1, HALT=2; encoding 3 is unused and recovers to RUN on the next clock edge.

Internal execute-stage shadow registers:
- execIsLoad <= decodeIsLoad & ~bubble
- execLoadDest <= decodeLoadDest

Load-use hazard:
- loadUse = execIsLoad & (execLoadDest != 0) & ((decodeUsesRd0 & decodeRfRdAdrx0 == execLoadDest) | (decodeUsesRd1 & decodeRfRdAdrx1 == execLoadDest)).
- Register 0 never causes a stall.

Transitions and outputs, in priority order:
- **RUN, branchTaken=1:**
  - Go to SQUASH and load squashCnt = BRANCH_SHADOW−1.
  - pcEn=1, irEn=1, bubble=1.
  - branchTaken takes priority over loadUse and haltReq in the same cycle.
- **RUN, loadUse=1:**
  - Stay in RUN; pcEn=0, irEn=0, bubble=1.
  - The stall lasts exactly one cycle, because the inserted bubble clears execIsLoad.
- **RUN, haltReq=1:**
  - Go to HALT; pcEn=0, irEn=0, bubble=1 starting this cycle.
- **RUN, otherwise:**
  - pcEn=1, irEn=1, bubble=0.
- **SQUASH:**
  - doBranchHeld=1, bubble=1, pcEn=1, irEn=1.
  - branchTaken, loadUse and haltReq are all ignored. A pending haltReq is acted on in RUN afterwards.
  - When squashCnt=0, go to RUN; otherwise decrement squashCnt.
- **HALT:**
  - pcEn=0, irEn=0, bubble=1.
  - resumeReq=1 returns to RUN on the next edge; branchTaken is ignored.

Performance counter:
- stallCount increments in any cycle with pcEn=0 and saturates at all-ones; it does not wrap.

## Timing
- pcEn, irEn, bubble: combinational (Mealy) from state and current-cycle inputs; zero-cycle latency from loadUse, branchTaken and haltReq.
- doBranchHeld, ctlState: registered, Moore outputs.
- Taken branch: doBranchHeld is high for exactly BRANCH_SHADOW cycles, starting the cycle after the branchTaken pulse. bubble is high for BRANCH_SHADOW+1 cycles.
- Halt: haltReq asserted in RUN freezes the PC that same cycle. resumeReq in HALT restores pcEn=1 one cycle later.
- Reset (rst_n=0, asynchronous): state=RUN, squashCnt=0, execIsLoad=0, execLoadDest=0, stallCount=0, doBranchHeld=0. Resulting combinational outputs: pcEn=1, irEn=1, bubble=0, unless haltReq or branchTaken is asserted during reset.
- Reset asserted mid-SQUASH or mid-HALT aborts immediately to RUN; no squash cycles remain pending.

## Structure
- Package pipe_ctl_pkg holds:
  - the state typedef and encodings RUN, SQUASH, HALT;
  - default BRANCH_SHADOW;
  - ZERO_REG = 5'd0.
- One sub-module, squash_counter: loadable down-counter of width $clog2(BRANCH_SHADOW) with a zero flag, instantiated once.
- Hazard compare and next-state logic stay in pipe_hazard_ctl.

## Test plan
- Load to r3 in decode, next instruction reads r3 via Rd1 → exactly one cycle of pcEn=0, bubble=1; stallCount goes 0→1; the following cycle is RUN with pcEn=1.
- Load to r0, next instruction reads r0 → no stall; pcEn stays 1. Load to r3, next instruction reads r3 with decodeUsesRd0=0 and decodeUsesRd1=0 → no stall.
- branchTaken pulse with BRANCH_SHADOW=3 → doBranchHeld high for 3 cycles, bubble high for 4 cycles, ctlState goes 0→1→1→1→0. A second branchTaken inside the window is ignored.
- branchTaken and loadUse in the same cycle → SQUASH is entered; pcEn=1 and no stall cycle is counted.
- haltReq for 5 cycles then resumeReq → pcEn=0 for 5+1 cycles, stallCount=6. haltReq raised during SQUASH → HALT is entered only after SQUASH exits.
- rst_n dropped mid-SQUASH → doBranchHeld falls immediately, without waiting for a clock edge. After release: ctlState=0, stallCount=0. With CNT_W=2, driving 5 stall cycles leaves stallCount saturated at 3.
